// File: rtl/heartsense_pkg.sv
// Shared types and defaults for the heart-rate sensor poll path.
// Holds the scheduler state encoding, bus addresses and alarm thresholds.
package heartsense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT,
        SKIP,
        NEXT
    } state_t;

    localparam logic [7:0] HS_DEV_ADDR = 8'h57;
    localparam logic [7:0] HS_REG_BASE = 8'h05;
    localparam logic [7:0] HS_LOW_TH   = 8'd40;
    localparam logic [7:0] HS_HIGH_TH  = 8'd180;

    function automatic logic hr_out_of_range(input logic [7:0] v,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        return (v < lo) || (v > hi);
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running frame period counter; tick is high on the last count.
// Runs continuously out of reset, independent of the scheduler enable.
module poll_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk_core,
    input  logic reset,
    output logic tick
);
    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(PERIOD - 1));

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Periodic burst reader for the heart-rate sensor over the shared I2C master.
// Optional POLL_AVG_EN: alarm evaluates a 4-sample moving average of byte 0.
module i2c_poll_scheduler
    import heartsense_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = HS_DEV_ADDR,
    parameter logic [7:0] REG_BASE = HS_REG_BASE,
    parameter int         NUM_REGS = 4,
    parameter int         PERIOD   = 1000,
    parameter logic [7:0] TIMEOUT  = 8'd255,
    parameter logic [7:0] LOW_TH   = HS_LOW_TH,
    parameter logic [7:0] HIGH_TH  = HS_HIGH_TH
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       enable,
    input  logic       busy_I2C,
    input  logic [7:0] din_I2C,
    output logic [7:0] add_I2C,
    output logic [7:0] reg_I2C,
    output logic       ler_i2c,
    output logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       frame_done,
    output logic       alarma,
    output logic       timeout_err
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t     state;
    logic [3:0] idx;
    logic [7:0] to_cnt;
    logic       tick;
    logic       alarm_upd;
    logic       alarm_val;

    poll_timer #(.PERIOD(PERIOD)) u_timer (
        .clk_core (clk_core),
        .reset    (reset),
        .tick     (tick)
    );

`ifdef POLL_AVG_EN
    logic [7:0] samp [4];
    logic [9:0] sum;
    logic [1:0] nfill;
    logic [9:0] sum_nxt;
    logic       push;

    assign push      = (state == WAIT) && !busy_I2C && (idx == 4'd0);
    // Oldest sample leaves as the new one enters; sum never underflows.
    assign sum_nxt   = sum + {2'b00, din_I2C} - {2'b00, samp[3]};
    assign alarm_upd = (nfill == 2'd3);
    assign alarm_val = hr_out_of_range(sum_nxt[9:2], LOW_TH, HIGH_TH);

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            samp[0] <= '0;
            samp[1] <= '0;
            samp[2] <= '0;
            samp[3] <= '0;
            sum     <= '0;
            nfill   <= '0;
        end else if (push) begin
            samp[0] <= din_I2C;
            samp[1] <= samp[0];
            samp[2] <= samp[1];
            samp[3] <= samp[2];
            sum     <= sum_nxt;
            if (nfill != 2'd3) nfill <= nfill + 2'd1;
        end
    end
`else
    assign alarm_upd = 1'b1;
    assign alarm_val = hr_out_of_range(din_I2C, LOW_TH, HIGH_TH);
`endif

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            to_cnt      <= '0;
            add_I2C     <= DEV_ADDR;
            reg_I2C     <= REG_BASE;
            ler_i2c     <= 1'b0;
            rd_idx      <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            frame_done  <= 1'b0;
            alarma      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state   <= REQ;
                        idx     <= '0;
                        reg_I2C <= REG_BASE;
                        ler_i2c <= 1'b1;
                        to_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (busy_I2C) begin
                        state   <= WAIT;
                        ler_i2c <= 1'b0;
                        to_cnt  <= '0;
                    end else if (to_cnt == TIMEOUT) begin
                        state       <= SKIP;
                        ler_i2c     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                WAIT: begin
                    // Capture on the first cycle busy is seen low: one-cycle latency.
                    if (!busy_I2C) begin
                        state    <= CAPT;
                        rd_data  <= din_I2C;
                        rd_idx   <= idx;
                        rd_valid <= 1'b1;
                        if (idx == 4'd0 && alarm_upd) alarma <= alarm_val;
                    end else if (to_cnt == TIMEOUT) begin
                        state       <= SKIP;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                CAPT, SKIP: begin
                    state <= NEXT;
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        idx     <= idx + 4'd1;
                        reg_I2C <= REG_BASE + {4'b0000, idx + 4'd1};
                        ler_i2c <= 1'b1;
                        to_cnt  <= '0;
                        state   <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Scoreboard bench for i2c_poll_scheduler with a simple I2C master model.
module tb_i2c_poll_scheduler;

    logic       clk_core = 1'b0;
    logic       reset;
    logic       enable;
    logic       busy_I2C;
    logic [7:0] din_I2C;
    logic [7:0] add_I2C;
    logic [7:0] reg_I2C;
    logic       ler_i2c;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_done;
    logic       alarma;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;
    int frame_cnt = 0;
    int bus_mode = 0;          // 0: master responds, 1: master never goes busy
    logic [7:0]  tab [4];
    logic [11:0] rd_q [$];     // {idx, data}
    logic [7:0]  req_q [$];    // expected reg_I2C per request

    always #5 clk_core = ~clk_core;

    i2c_poll_scheduler #(
        .PERIOD   (20),
        .NUM_REGS (4),
        .TIMEOUT  (8'd10)
    ) dut (
        .clk_core    (clk_core),
        .reset       (reset),
        .enable      (enable),
        .busy_I2C    (busy_I2C),
        .din_I2C     (din_I2C),
        .add_I2C     (add_I2C),
        .reg_I2C     (reg_I2C),
        .ler_i2c     (ler_i2c),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .frame_done  (frame_done),
        .alarma      (alarma),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Master model: busy rises one cycle after the request, stays high 3 cycles.
    initial begin
        busy_I2C = 1'b0;
        din_I2C  = 8'h00;
        forever begin
            @(negedge clk_core);
            if (ler_i2c && bus_mode == 0 && !busy_I2C) begin
                @(negedge clk_core);
                busy_I2C = 1'b1;
                din_I2C  = tab[2'(reg_I2C - 8'h05)];
                repeat (3) @(negedge clk_core);
                busy_I2C = 1'b0;
            end
        end
    end

    // Read-data monitor: pops the scoreboard on every strobe.
    int since_busy = 100;
    always @(posedge clk_core) begin
        #1;
        if (busy_I2C) since_busy = 0;
        else if (since_busy < 100) since_busy++;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got idx %0d data %0d, expected no strobe", rd_idx, rd_data);
            end else begin
                logic [11:0] e;
                e = rd_q.pop_front();
                chk("rd_idx", 32'(rd_idx), 32'(e[11:8]));
                chk("rd_data", 32'(rd_data), 32'(e[7:0]));
                chk("rd_latency", 32'(since_busy), 32'd1);
            end
        end
    end

    // Request monitor: register address at each new request.
    logic ler_prev = 1'b0;
    always @(posedge clk_core) begin
        #1;
        if (ler_i2c && !ler_prev) begin
            if (req_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL req_unexpected: got reg 0x%0h, expected no request", reg_I2C);
            end else begin
                chk("reg_I2C", 32'(reg_I2C), 32'(req_q.pop_front()));
                chk("add_I2C", 32'(add_I2C), 32'h57);
            end
        end
        ler_prev = ler_i2c;
        if (frame_done) frame_cnt++;
    end

    task automatic start_frame(input logic [7:0] d0);
        tab[0] = d0;
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back({4'(i), tab[i]});
            req_q.push_back(8'h05 + 8'(i));
        end
    endtask

    task automatic wait_frame(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_core);
            if (frame_done) break;
        end
        tests++;
        if (!frame_done) begin
            fails++;
            $display("FAIL %s: got no frame_done within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic wait_ler(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_core);
            if (ler_i2c) break;
        end
        tests++;
        if (!ler_i2c) begin
            fails++;
            $display("FAIL %s: got no ler_i2c within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic count_ler(input int cycles, input string name);
        int seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk_core);
            if (ler_i2c) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    logic [7:0] vec_d [7] = '{8'd80, 8'd30, 8'd80, 8'd181, 8'd180, 8'd40, 8'd39};
    logic       vec_a [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        tab[0] = 8'd80; tab[1] = 8'd81; tab[2] = 8'd82; tab[3] = 8'd83;
        repeat (3) @(negedge clk_core);
        chk("rst_add", 32'(add_I2C), 32'h57);
        chk("rst_reg", 32'(reg_I2C), 32'h05);
        chk("rst_ler", 32'(ler_i2c), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_alarma", 32'(alarma), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;

        // Alarm boundaries on byte 0, one frame each.
        for (int i = 0; i < 7; i++) begin
            start_frame(vec_d[i]);
            wait_frame(200, "frame_vec");
            chk("alarma_vec", 32'(alarma), 32'(vec_a[i]));
        end
        chk("timeout_err_clean", 32'(timeout_err), 32'd0);

        // Master never responds: four skips, frame still completes.
        bus_mode = 1;
        for (int i = 0; i < 4; i++) req_q.push_back(8'h05 + 8'(i));
        wait_frame(300, "frame_timeout");
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        chk("alarma_hold_skip", 32'(alarma), 32'd1);
        bus_mode = 0;

        // Disabled at the tick: no request for two full periods.
        enable = 1'b0;
        count_ler(45, "ler_while_disabled");

        // Enable dropped mid-frame: frame finishes, later ticks ignored.
        start_frame(8'd200);
        enable = 1'b1;
        wait_ler(100, "mid_frame_start");
        enable = 1'b0;
        wait_frame(200, "frame_mid_disable");
        chk("alarma_mid", 32'(alarma), 32'd1);
        count_ler(45, "ler_after_mid_disable");

        // Reset asserted while waiting on the bus.
        tab[0] = 8'd30;
        req_q.push_back(8'h05);
        enable = 1'b1;
        wait_ler(100, "rst_frame_start");
        for (int n = 0; n < 20; n++) begin
            if (!ler_i2c && busy_I2C) break;
            @(negedge clk_core);
        end
        chk("in_wait_busy", 32'(busy_I2C), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ler", 32'(ler_i2c), 32'd0);
        chk("midrst_reg", 32'(reg_I2C), 32'h05);
        chk("midrst_add", 32'(add_I2C), 32'h57);
        chk("midrst_alarma", 32'(alarma), 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk_core);
        reset = 1'b0;
        start_frame(8'd80);
        wait_frame(200, "frame_after_reset");
        chk("alarma_after_reset", 32'(alarma), 32'd0);
        enable = 1'b0;

        repeat (10) @(negedge clk_core);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("frame_count", 32'(frame_cnt), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
